// File: rtl/idea_pkg.sv
// rtl/idea_pkg.sv - shared types, widths and index helpers for the IDEA key schedule
//
// Purpose: word width, the mulmod identity constant, the key count for a
// given round count, the FSM and operation enums, and the mapping from a
// decryption output slot (row r, column k) to its encryption source key.
// Ports: none (package).

package idea_pkg;

  localparam int IDEA_W = 16;
  localparam logic [IDEA_W-1:0] MULMOD_ONE = 16'd1;

  typedef enum logic [2:0] {IDLE, LOAD, SEL, INV, OUT} state_e;
  typedef enum logic [1:0] {OP_PASS, OP_NEG, OP_INV} op_e;

  function automatic int nk_of(input int rounds);
    return 6 * rounds + 4;
  endfunction

  // Source index of the encryption key feeding decryption slot (r, k).
  // Rows 1..rounds-1 swap the two additive keys; the first row and the
  // output-transform row keep them in place.
  function automatic int src_index(input int rounds, input int r, input int k);
    int  base;
    logic mid;
    base = 6 * (rounds - r);
    mid  = (r >= 1) && (r <= rounds - 1);
    case (k)
      0:       return base;
      1:       return mid ? base + 2 : base + 1;
      2:       return mid ? base + 1 : base + 2;
      3:       return base + 3;
      4:       return base - 2;
      default: return base - 1;
    endcase
  endfunction

  function automatic op_e op_of(input int k);
    if (k == 0 || k == 3) return OP_INV;
    else if (k == 1 || k == 2) return OP_NEG;
    else return OP_PASS;
  endfunction

endpackage

// File: rtl/inmultire.sv
// rtl/inmultire.sv - combinational multiplication modulo 65537
//
// Purpose: p = a * b mod 65537, where the all-zero word stands for 65536.
// Ports:
//   a, b : operands (IDEA_W bits)
//   p    : product (IDEA_W bits, 65536 encoded as 0)

module inmultire
  import idea_pkg::*;
(
  input  logic [IDEA_W-1:0] a,
  input  logic [IDEA_W-1:0] b,
  output logic [IDEA_W-1:0] p
);

  logic [2*IDEA_W-1:0] prod;
  logic [IDEA_W-1:0]   lo;
  logic [IDEA_W-1:0]   hi;

  always_comb begin
    prod = {{IDEA_W{1'b0}}, a} * {{IDEA_W{1'b0}}, b};
    lo   = prod[IDEA_W-1:0];
    hi   = prod[2*IDEA_W-1:IDEA_W];
    // 65536 == -1 (mod 65537), so a zero operand just negates the other
    // operand: 65537 - b, which wraps to 1 - b in 16 bits.
    if (a == '0)
      p = MULMOD_ONE - b;
    else if (b == '0)
      p = MULMOD_ONE - a;
    // 2^16 == -1 (mod 65537), so hi*2^16 + lo == lo - hi.
    else if (lo >= hi)
      p = lo - hi;
    else
      p = lo - hi + MULMOD_ONE;  // + 65537, truncated to 16 bits
  end

endmodule

// File: rtl/idea_dec_key_gen.sv
// rtl/idea_dec_key_gen.sv - IDEA encryption-to-decryption subkey converter
//
// Purpose: buffers the NK = 6*ROUNDS+4 encryption subkeys and streams out the
// decryption subkeys in consumption order, computing multiplicative inverses
// (Fermat, x^65535 mod 65537) and additive inverses on the fly.
// Optional build macro: IDEA_DKEY_SELFCHECK_EN adds the sticky chk_err output,
// which flags an inverse whose product with its input is not 1.
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   ek_valid/ek_ready/ek_data    : encryption subkey input stream, Z[0..NK-1]
//   dk_valid/dk_ready/dk_data    : decryption subkey output stream
//   dk_last                      : marks the final decryption subkey
//   busy                         : high whenever the FSM is not IDLE
//   chk_err (macro only)         : sticky inverse self-check error

module idea_dec_key_gen
  import idea_pkg::*;
#(
  parameter int ROUNDS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ek_valid,
  output logic              ek_ready,
  input  logic [IDEA_W-1:0] ek_data,
  output logic              dk_valid,
  input  logic              dk_ready,
  output logic [IDEA_W-1:0] dk_data,
  output logic              dk_last,
  output logic              busy
`ifdef IDEA_DKEY_SELFCHECK_EN
  ,
  output logic              chk_err
`endif
);

  localparam int NK = nk_of(ROUNDS);
  localparam int AW = $clog2(NK);
  localparam int RW = $clog2(ROUNDS + 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     j_q, j_d;
  logic [RW-1:0]     r_q, r_d;
  logic [2:0]        k_q, k_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [IDEA_W-1:0] x_q, x_d;
  logic [IDEA_W-1:0] acc_q, acc_d;
  logic [IDEA_W-1:0] dk_data_q, dk_data_d;
  logic              ek_ready_q, ek_ready_d;
  logic              dk_valid_q, dk_valid_d;
  logic              dk_last_q, dk_last_d;
  logic              busy_q, busy_d;

  logic [IDEA_W-1:0] key_mem [NK];
  logic              ek_fire;
  logic              last_out;
  int                sel_src;
  op_e               sel_op;
  logic [IDEA_W-1:0] sel_key;
  logic [IDEA_W-1:0] mul_b;
  logic [IDEA_W-1:0] mul_p;

  assign ek_fire  = ek_valid & ek_ready_q;
  assign last_out = (j_q == AW'(NK - 1));

  // Key buffer carries no reset: its contents are only read after a full load.
  always_ff @(posedge clk) begin
    if (ek_fire) key_mem[wcnt_q] <= ek_data;
  end

  always_comb begin
    sel_src = src_index(ROUNDS, int'(r_q), int'(k_q));
    sel_op  = op_of(int'(k_q));
    sel_key = key_mem[AW'(sel_src)];
  end

  // One multiplier shared by the square and multiply steps: even counts
  // square the accumulator, odd counts multiply it by the original key.
  assign mul_b = cnt_q[0] ? x_q : acc_q;

  inmultire u_mul (
    .a (acc_q),
    .b (mul_b),
    .p (mul_p)
  );

`ifdef IDEA_DKEY_SELFCHECK_EN
  op_e               op_q, op_d;
  logic              chk_err_q, chk_err_d;
  logic [IDEA_W-1:0] chk_p;

  inmultire u_chk (
    .a (x_q),
    .b (acc_q),
    .p (chk_p)
  );

  assign chk_err = chk_err_q;
`endif

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    j_d        = j_q;
    r_d        = r_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    x_d        = x_q;
    acc_d      = acc_q;
    dk_data_d  = dk_data_q;
    ek_ready_d = ek_ready_q;
    dk_valid_d = dk_valid_q;
    dk_last_d  = dk_last_q;
    busy_d     = busy_q;
`ifdef IDEA_DKEY_SELFCHECK_EN
    op_d       = op_q;
    chk_err_d  = chk_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (ek_valid) begin
          wcnt_d  = AW'(1);
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef IDEA_DKEY_SELFCHECK_EN
          chk_err_d = 1'b0;
`endif
        end
      end

      LOAD: begin
        if (ek_valid) begin
          if (wcnt_q == AW'(NK - 1)) begin
            ek_ready_d = 1'b0;
            wcnt_d     = '0;
            j_d        = '0;
            r_d        = '0;
            k_d        = '0;
            state_d    = SEL;
          end else begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end

      SEL: begin
        x_d   = sel_key;
        acc_d = sel_key;
        cnt_d = '0;
`ifdef IDEA_DKEY_SELFCHECK_EN
        op_d  = sel_op;
`endif
        if (sel_op == OP_INV) begin
          state_d = INV;
        end else begin
          dk_data_d  = (sel_op == OP_NEG) ? -sel_key : sel_key;
          dk_valid_d = 1'b1;
          dk_last_d  = last_out;
          state_d    = OUT;
        end
      end

      INV: begin
        acc_d = mul_p;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd29) begin
          dk_data_d  = mul_p;
          dk_valid_d = 1'b1;
          dk_last_d  = last_out;
          state_d    = OUT;
        end
      end

      OUT: begin
`ifdef IDEA_DKEY_SELFCHECK_EN
        if (op_q == OP_INV && chk_p != MULMOD_ONE) chk_err_d = 1'b1;
`endif
        if (dk_ready) begin
          dk_valid_d = 1'b0;
          dk_last_d  = 1'b0;
          if (last_out) begin
            ek_ready_d = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            j_d     = j_q + AW'(1);
            state_d = SEL;
            if (k_q == 3'd5) begin
              k_d = '0;
              r_d = r_q + RW'(1);
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      j_q        <= '0;
      r_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      dk_data_q  <= '0;
      ek_ready_q <= 1'b1;
      dk_valid_q <= 1'b0;
      dk_last_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef IDEA_DKEY_SELFCHECK_EN
      op_q       <= OP_PASS;
      chk_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      j_q        <= j_d;
      r_q        <= r_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      dk_data_q  <= dk_data_d;
      ek_ready_q <= ek_ready_d;
      dk_valid_q <= dk_valid_d;
      dk_last_q  <= dk_last_d;
      busy_q     <= busy_d;
`ifdef IDEA_DKEY_SELFCHECK_EN
      op_q       <= op_d;
      chk_err_q  <= chk_err_d;
`endif
    end
  end

  assign ek_ready = ek_ready_q;
  assign dk_valid = dk_valid_q;
  assign dk_data  = dk_data_q;
  assign dk_last  = dk_last_q;
  assign busy     = busy_q;

endmodule

// File: doc/idea_dec_key_gen.md
Name: idea_dec_key_gen

Overview:
- Converts the IDEA encryption subkey schedule into the decryption subkey schedule.
- Accepts 6*ROUNDS+4 encryption subkeys as a stream and buffers them.
- Emits the decryption subkeys in consumption order, one per handshake.
- Inverse-direction companion of the encryption round datapath; feeds the decryption round chain, which reuses the round datapath with these keys.

Parameters:
- ROUNDS, 8, number of full rounds; key count NK = 6*ROUNDS+4 (52 by default).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ek_valid  in  1  encryption subkey valid
- ek_ready  out  1  block accepts encryption subkey
- ek_data  in  16  encryption subkey Z[i], in order i=0..NK-1
- dk_valid  out  1  decryption subkey valid
- dk_ready  in  1  consumer accepts decryption subkey
- dk_data  out  16  decryption subkey
- dk_last  out  1  high with final decryption subkey (index NK-1)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; ek_ready=1, dk_valid=0, dk_last=0, busy=0; counters cleared; buffer contents don't-care.
- Transfers occur only on cycles where valid&ready are both high.
- Once dk_valid is raised, dk_data and dk_last hold stable until the transfer.
- IDLE: the first ek transfer writes buf[0] and moves to LOAD.
- LOAD: writes buf[wcnt]; ek_ready stays 1 until index NK-1 is accepted, then drops to 0 and the FSM goes to SEL.
- SEL: computes the source index s and op for output index j = 6r+k, with 1-based rr = r+1 and 0-based source indices:
  - k=0: inv(Z[6(ROUNDS-r)])
  - k=3: inv(Z[6(ROUNDS-r)+3])
  - k=1: neg(Z[6(ROUNDS-r)+2]) when 1<=r<=ROUNDS-1, otherwise neg(Z[6(ROUNDS-r)+1])
  - k=2: neg(Z[6(ROUNDS-r)+1]) when 1<=r<=ROUNDS-1, otherwise neg(Z[6(ROUNDS-r)+2])
  - k=4: Z[6(ROUNDS-1-r)+4]
  - k=5: Z[6(ROUNDS-1-r)+5]
  - Row r=ROUNDS (the output transform) has k=0..3 only.
  - neg and pass ops go to OUT next cycle. inv goes to INV.
- neg: (65536 - x) mod 65536, 16-bit wrap; neg(0)=0.
- INV: Fermat inversion x^65535 mod 65537, with value 0 representing 65536.
  - acc<=x, then 15 iterations of {SQ: acc<=acc*acc; MUL: acc<=acc*x}.
  - Exactly 30 cycles, then OUT.
  - inv(0)=0 and inv(1)=1 fall out naturally; no special-casing.
- OUT: dk_valid=1. On transfer, j increments and the FSM goes to SEL; at j=NK-1 (dk_last=1) it goes to IDLE with ek_ready=1.
- Back-pressure: dk_ready low holds OUT indefinitely; no data loss.
- ek_valid while the FSM is not accepting (ek_ready=0) is ignored.
- Per-key latency: pass/neg is 2 cycles SEL->OUT valid; inv is 32 cycles.
- rst_n assertion mid-LOAD/INV/OUT aborts immediately to the reset state; partial results are discarded.

Optional Feature:
- IDEA_DKEY_SELFCHECK_EN defined:
  - Extra output port chk_err (1 bit, reset 0).
  - In OUT for inv ops, mulmod(x, acc) != 1 sets chk_err sticky until reset.
  - chk_err is also cleared when a new IDLE->LOAD transfer starts.
- Undefined: no port, no checker logic.

Decomposition:
- Package idea_pkg:
  - IDEA_W=16, MULMOD_ONE=16'd1
  - NK function of ROUNDS
  - state enum {IDLE, LOAD, SEL, INV, OUT}
  - op enum {OP_PASS, OP_NEG, OP_INV}
- Sub-module: the existing combinational modulo-65537 multiplier (inmultire), instantiated once and shared by SQ/MUL via an operand mux.
- The self-check instantiates a second copy.

Test Plan:
- All Z[i]=0x0001: 52 outputs; inverse/pass slots = 0x0001, neg slots = 0xFFFF; dk_last only on the 52nd; ek_ready low from after the 52nd input until return to IDLE.
- Z[0]=2, Z[3]=0xFFFF, Z[1]=0, Z[2]=0x8000, others 0: output-transform row (j=48..51) = 32769, 0x0000, 0x8000, 32768.
- Z[i]=i: rows 0 and 8 unswapped, rows 1..7 have k=1/k=2 swapped. Row 1 k=1 = neg(Z[44])=0xFFD4 and k=2 = neg(Z[43])=0xFFD5. Row 0 k=4 = Z[46]=46 and k=5 = Z[47]=47.
- Random 52 keys vs reference model; dk_ready toggled randomly -> stream identical to the unthrottled run, no drops or duplicates; inv latency exactly 32 cycles with dk_ready=1.
- rst_n pulsed low during INV of j=3 -> dk_valid=0 and ek_ready=1 immediately; a fresh full load produces a correct complete stream.
- With IDEA_DKEY_SELFCHECK_EN: normal run -> chk_err=0; forcing acc corrupt via bench force -> chk_err=1 stays set until the next load start.
